// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with tagged beats; `define ALU_PIPE_SAT_EN adds saturating ADDS/SUBS.
// Latency: a beat accepted at edge N is registered in stage 1 at N and on out_* after edge N+1.
// Backpressure: in_ready = !s1_valid || !out_valid || out_ready; out_* hold while out_valid && !out_ready.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
`ifdef ALU_PIPE_SAT_EN
    localparam logic [3:0] OP_ADDS = 4'b1011;
    localparam logic [3:0] OP_SUBS = 4'b1100;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [TAG_W-1:0] tag;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             neg;
    } res_t;

    logic s1_valid;
    logic s2_valid;
    op_t  s1_q;
    res_t s2_q;
    res_t res_d;
    logic adv1;
    logic adv2;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1 && rst_n;
    assign out_valid = s2_valid;

    // Execute stage: everything below works on the stage-1 registers only.
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic             ovf_add;
    logic             ovf_sub;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sra_y;
    logic             slt;
    logic             sltu;

    assign sum_add = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    assign sum_sub = {1'b0, s1_q.a} + {1'b0, ~s1_q.b} + {{WIDTH{1'b0}}, 1'b1};
    assign ovf_add = (s1_q.a[WIDTH-1] == s1_q.b[WIDTH-1]) && (sum_add[WIDTH-1] != s1_q.a[WIDTH-1]);
    assign ovf_sub = (s1_q.a[WIDTH-1] != s1_q.b[WIDTH-1]) && (sum_sub[WIDTH-1] != s1_q.a[WIDTH-1]);
    assign sh      = s1_q.b[SHW-1:0];
    assign sra_y   = $signed(s1_q.a) >>> sh;
    assign slt     = $signed(s1_q.a) < $signed(s1_q.b);
    assign sltu    = s1_q.a < s1_q.b;

    always_comb begin
        res_d     = '0;
        res_d.tag = s1_q.tag;
        case (s1_q.op)
            OP_ADD: begin
                res_d.y     = sum_add[WIDTH-1:0];
                res_d.carry = sum_add[WIDTH];
                res_d.ovf   = ovf_add;
            end
            OP_SUB: begin
                res_d.y     = sum_sub[WIDTH-1:0];
                res_d.carry = sum_sub[WIDTH];
                res_d.ovf   = ovf_sub;
            end
            OP_AND:  res_d.y = s1_q.a & s1_q.b;
            OP_OR:   res_d.y = s1_q.a | s1_q.b;
            OP_XOR:  res_d.y = s1_q.a ^ s1_q.b;
            OP_NOR:  res_d.y = ~(s1_q.a | s1_q.b);
            OP_SLL:  res_d.y = s1_q.a << sh;
            OP_SRL:  res_d.y = s1_q.a >> sh;
            OP_SLT:  res_d.y = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: res_d.y = {{(WIDTH-1){1'b0}}, sltu};
            OP_SRA:  res_d.y = sra_y;
`ifdef ALU_PIPE_SAT_EN
            // Overflow direction follows operand A's sign for both add and subtract.
            OP_ADDS: begin
                res_d.y     = ovf_add ? (s1_q.a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum_add[WIDTH-1:0];
                res_d.carry = sum_add[WIDTH];
                res_d.ovf   = ovf_add;
            end
            OP_SUBS: begin
                res_d.y     = ovf_sub ? (s1_q.a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum_sub[WIDTH-1:0];
                res_d.carry = sum_sub[WIDTH];
                res_d.ovf   = ovf_sub;
            end
`endif
            default: res_d.y = '0;
        endcase
        res_d.zero = (res_d.y == '0);
        res_d.neg  = res_d.y[WIDTH-1];
    end

    // Payload registers load only on a real transfer so idle cycles leave the datapath quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
            end
            if (in_valid && adv1) begin
                s1_q <= '{a: in_a, b: in_b, op: in_op, tag: in_tag};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && adv2) begin
                s2_q <= res_d;
            end
        end
    end

    assign out_y     = s2_q.y;
    assign out_tag   = s2_q.tag;
    assign out_carry = s2_q.carry;
    assign out_ovf   = s2_q.ovf;
    assign out_zero  = s2_q.zero;
    assign out_neg   = s2_q.neg;

endmodule
